// File: rtl/jtag_master_seq.sv
// jtag_master_seq: command-driven JTAG TAP master that runs TLR, IR-load and DR-shift sequences.
// Define JTAG_MASTER_TRST_EN to add jtag_trst_n, pulsed low for 2 TCK periods at the start of every TLR.
module jtag_master_seq #(
  parameter int IR_W    = 4,
  parameter int DR_MAX  = 32,
  parameter int CLK_DIV = 20,
  localparam int LW     = $clog2(DR_MAX + 1)
) (
  input  logic              internal_clk,
  input  logic              jtag_rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LW-1:0]     cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              jtag_clk,
  output logic              jtag_mode,
  output logic              jtag_digital_input,
`ifdef JTAG_MASTER_TRST_EN
  output logic              jtag_trst_n,
`endif
  input  logic              jtag_digital_output
);

`ifdef JTAG_MASTER_TRST_EN
  localparam int TRST_N = 2;
`else
  localparam int TRST_N = 0;
`endif
  localparam int TLR_N = 6 + TRST_N;
  localparam int CW    = $clog2(DR_MAX + TLR_N + 1);
  localparam int DW    = $clog2(2 * CLK_DIV);

  // Each state is named after the TAP state seen at the TCK rising edge of its period(s).
  typedef enum logic [3:0] {
    S_POR_TLR, S_IDLE, S_TLR, S_RTI, S_SEL_DR, S_SEL_IR,
    S_CAPTURE, S_SHIFT, S_EXIT1, S_UPDATE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     len_q, len_d;
  logic [DW-1:0]     div_q, div_d;
  logic              tck_q, tck_d;
  logic              is_ir_q, is_ir_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DR_MAX-1:0] rsp_data_q, rsp_data_d;
  logic [DR_MAX-1:0] sh_q, sh_d;

  logic accept, in_period, rise, period_end;

  assign accept     = cmd_valid & (state_q == S_IDLE);
  assign in_period  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign rise       = in_period && (div_q == DW'(CLK_DIV - 1));
  assign period_end = in_period && (div_q == DW'(2 * CLK_DIV - 1));

  always_ff @(posedge internal_clk or negedge jtag_rstn) begin
    if (!jtag_rstn) begin
      state_q     <= S_POR_TLR;
      cnt_q       <= '0;
      len_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      is_ir_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      is_ir_q     <= is_ir_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge internal_clk) begin
    sh_q <= sh_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          case (cmd_op)
            2'd0:       state_d = S_TLR;
            2'd1, 2'd2: state_d = S_RTI;
            default:    state_d = S_DONE;
          endcase
        end
      end
      S_DONE: begin
        if (div_q == DW'(CLK_DIV)) state_d = S_IDLE;
      end
      default: begin
        if (period_end) begin
          cnt_d = '0;
          case (state_q)
            S_POR_TLR, S_TLR: begin
              if (cnt_q == CW'(TLR_N - 1))
                state_d = (state_q == S_POR_TLR) ? S_IDLE : S_DONE;
              else
                cnt_d = cnt_q + 1'b1;
            end
            S_RTI:     state_d = S_SEL_DR;
            S_SEL_DR:  state_d = is_ir_q ? S_SEL_IR : S_CAPTURE;
            S_SEL_IR:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = (len_q == '0) ? S_EXIT1 : S_SHIFT;
            S_SHIFT: begin
              if (cnt_q == len_q - 1'b1) state_d = S_EXIT1;
              else                       cnt_d   = cnt_q + 1'b1;
            end
            S_EXIT1:   state_d = S_UPDATE;
            S_UPDATE:  state_d = S_DONE;
            default:   state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    div_d       = '0;
    tck_d       = 1'b0;
    len_d       = len_q;
    is_ir_d     = is_ir_q;
    sh_d        = sh_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept) begin
        is_ir_d    = (cmd_op == 2'd1);
        sh_d       = cmd_data;
        rsp_data_d = '0;
        rsp_err_d  = (cmd_op == 2'd3) || ((cmd_op == 2'd2) && (cmd_len > LW'(DR_MAX)));
        if (cmd_op == 2'd1)             len_d = CW'(IR_W);
        else if (cmd_len > LW'(DR_MAX)) len_d = CW'(DR_MAX);
        else                            len_d = CW'(cmd_len);
        // Reserved op: skip straight to the response cycle of DONE.
        if (cmd_op == 2'd3) begin
          div_d       = DW'(CLK_DIV);
          rsp_valid_d = 1'b1;
        end
      end
    end else if (state_q == S_DONE) begin
      div_d       = (div_q == DW'(CLK_DIV)) ? '0 : div_q + 1'b1;
      rsp_valid_d = (div_q == DW'(CLK_DIV - 1));
    end else begin
      div_d = period_end ? '0 : div_q + 1'b1;
      tck_d = rise | (tck_q & ~period_end);
      if ((state_q == S_SHIFT) && rise && jtag_digital_output)
        rsp_data_d = rsp_data_q | (DR_MAX'(1) << cnt_q);
      if ((state_q == S_SHIFT) && period_end)
        sh_d = sh_q >> 1;
    end
  end

  always_comb begin
    jtag_mode          = 1'b0;
    jtag_digital_input = 1'b0;
    case (state_q)
      S_POR_TLR, S_TLR: jtag_mode = (cnt_q != CW'(TLR_N - 1));
      S_RTI:            jtag_mode = 1'b1;
      S_SEL_DR:         jtag_mode = is_ir_q;
      S_CAPTURE:        jtag_mode = (len_q == '0);
      S_SHIFT: begin
        jtag_mode          = (cnt_q == len_q - 1'b1);
        jtag_digital_input = sh_q[0];
      end
      S_EXIT1:          jtag_mode = 1'b1;
      default:          ;
    endcase
  end

`ifdef JTAG_MASTER_TRST_EN
  assign jtag_trst_n = !(((state_q == S_POR_TLR) || (state_q == S_TLR)) && (cnt_q < CW'(TRST_N)));
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign jtag_clk  = tck_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jtag_master_seq.sv
// Testbench for jtag_master_seq: behavioural TAP device, TMS/TDI recorder and spec-level expectations.
`timescale 1ns/1ps
module tb_jtag_master_seq;
  localparam int IR_W    = 4;
  localparam int DR_MAX  = 32;
  localparam int CLK_DIV = 20;
  localparam int LW      = $clog2(DR_MAX + 1);
`ifdef JTAG_MASTER_TRST_EN
  localparam int TLR_N = 8;
`else
  localparam int TLR_N = 6;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'd0;
  logic [LW-1:0]     cmd_len = '0;
  logic [DR_MAX-1:0] cmd_data = '0;
  logic              cmd_ready, rsp_valid, rsp_err, busy;
  logic [DR_MAX-1:0] rsp_data;
  logic              jtag_clk, jtag_mode, jtag_digital_input;
  logic              tdo = 1'b0;
`ifdef JTAG_MASTER_TRST_EN
  logic              trst_n;
`endif

  always #10 clk = ~clk;

  jtag_master_seq #(.IR_W(IR_W), .DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV)) dut (
    .internal_clk        (clk),
    .jtag_rstn           (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_len             (cmd_len),
    .cmd_data            (cmd_data),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .busy                (busy),
    .jtag_clk            (jtag_clk),
    .jtag_mode           (jtag_mode),
    .jtag_digital_input  (jtag_digital_input),
`ifdef JTAG_MASTER_TRST_EN
    .jtag_trst_n         (trst_n),
`endif
    .jtag_digital_output (tdo)
  );

  // IEEE 1149.1 TAP device: DR length and capture value are set by the stimulus.
  typedef enum int {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHD, T_E1D, T_PDR, T_E2D, T_UDR,
    T_SIR, T_CIR, T_SHI, T_E1I, T_PIR, T_E2I, T_UIR
  } tap_t;
  tap_t        tap = T_TLR;
  int          dr_n = 1;
  logic [63:0] dr_cap = 64'd0;
  logic [63:0] dr_sr = 64'd0;
  logic [63:0] ir_sr = 64'd0;

  always @(posedge jtag_clk) begin
    case (tap)
      T_TLR: tap <= jtag_mode ? T_TLR : T_RTI;
      T_RTI: tap <= jtag_mode ? T_SDR : T_RTI;
      T_SDR: tap <= jtag_mode ? T_SIR : T_CDR;
      T_CDR: begin
        dr_sr <= dr_cap & ((64'd1 << dr_n) - 64'd1);
        tap   <= jtag_mode ? T_E1D : T_SHD;
      end
      T_SHD: begin
        dr_sr <= (dr_sr >> 1) | (64'(jtag_digital_input) << (dr_n - 1));
        tap   <= jtag_mode ? T_E1D : T_SHD;
      end
      T_E1D: tap <= jtag_mode ? T_UDR : T_PDR;
      T_PDR: tap <= jtag_mode ? T_E2D : T_PDR;
      T_E2D: tap <= jtag_mode ? T_UDR : T_SHD;
      T_UDR: tap <= jtag_mode ? T_SDR : T_RTI;
      T_SIR: tap <= jtag_mode ? T_TLR : T_CIR;
      T_CIR: begin
        ir_sr <= 64'h1;
        tap   <= jtag_mode ? T_E1I : T_SHI;
      end
      T_SHI: begin
        ir_sr <= (ir_sr >> 1) | (64'(jtag_digital_input) << (IR_W - 1));
        tap   <= jtag_mode ? T_E1I : T_SHI;
      end
      T_E1I: tap <= jtag_mode ? T_UIR : T_PIR;
      T_PIR: tap <= jtag_mode ? T_E2I : T_PIR;
      T_E2I: tap <= jtag_mode ? T_UIR : T_SHI;
      default: tap <= jtag_mode ? T_SDR : T_RTI;
    endcase
  end

  always @(negedge jtag_clk) begin
    tdo <= (tap == T_SHD) ? dr_sr[0] : (tap == T_SHI) ? ir_sr[0] : 1'b0;
  end

  logic tms_log[$];
  logic tdi_log[$];
  time  rise_t[$];
  int   rv_count = 0;

  always @(posedge jtag_clk) begin
    tms_log.push_back(jtag_mode);
    tdi_log.push_back(jtag_digital_input);
    rise_t.push_back($time);
  end

  always @(posedge clk) begin
    if (rsp_valid) rv_count <= rv_count + 1;
  end

  int checks = 0;
  int errors = 0;
  bit exp_tms[$];
  bit exp_tdi[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit t, input bit d);
    exp_tms.push_back(t);
    exp_tdi.push_back(d);
  endtask

  // Expected TMS/TDI per TCK period, straight from the sequence tables.
  task automatic build_exp(input int op, input int l, input logic [31:0] d);
    exp_tms.delete();
    exp_tdi.delete();
    case (op)
      0: begin
        for (int i = 0; i < TLR_N - 1; i++) push(1'b1, 1'b0);
        push(1'b0, 1'b0);
      end
      1: begin
        push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) push(i == IR_W - 1, d[i]);
        push(1'b1, 1'b0); push(1'b0, 1'b0);
      end
      2: begin
        if (l == 0) begin
          push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0);
        end else begin
          push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
          for (int i = 0; i < l; i++) push(i == l - 1, d[i]);
          push(1'b1, 1'b0); push(1'b0, 1'b0);
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [63:0] exp_capture(input int n, input logic [63:0] cap,
                                              input int l, input logic [31:0] d);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < l; i++) r[i] = (i < n) ? cap[i] : d[i - n];
    return r;
  endfunction

  task automatic check_seq(input string tag, input int base);
    logic [63:0] ot, et, od, ed;
    int n;
    n  = tms_log.size() - base;
    ot = '0; et = '0; od = '0; ed = '0;
    check({tag, " periods"}, 64'(n), 64'(exp_tms.size()));
    for (int i = 0; i < 64; i++) begin
      if (i < n) begin
        ot[i] = tms_log[base + i];
        od[i] = tdi_log[base + i];
      end
      if (i < exp_tms.size()) begin
        et[i] = exp_tms[i];
        ed[i] = exp_tdi[i];
      end
    end
    check({tag, " tms"}, ot, et);
    check({tag, " tdi"}, od, ed);
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic issue(input string tag, input int op, input int len, input logic [31:0] d);
    wait_ready(tag);
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_len   = len[LW-1:0];
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input int op, input int len, input logic [31:0] d,
                        input int dn, input logic [63:0] dcap, input bit poke);
    int base, cyc, l, n;
    logic [63:0] cap, ecap;
    logic [31:0] held;
    dr_n   = dn;
    dr_cap = dcap;
    base   = tms_log.size();
    issue(tag, op, len, d);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 5000) begin
      if (poke && cyc == 60) begin
        check({tag, " busy"}, 64'(busy), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
      end
      if (cyc == 63) cmd_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (op == 3) check({tag, " op3 latency"}, 64'(cyc), 64'd0);
    check({tag, " ready in rsp"}, 64'(cmd_ready), 64'd0);
    l    = (op == 1) ? IR_W : (op == 2) ? ((len > DR_MAX) ? DR_MAX : len) : 0;
    n    = (op == 1) ? IR_W : dn;
    cap  = (op == 1) ? 64'h1 : (dcap & ((64'd1 << dn) - 64'd1));
    ecap = (op == 1 || op == 2) ? exp_capture(n, cap, l, d) : 64'd0;
    check({tag, " rsp_data"}, 64'(rsp_data), ecap);
    check({tag, " rsp_err"}, 64'(rsp_err), 64'((op == 3) || (op == 2 && len > DR_MAX)));
    build_exp(op, l, d);
    check_seq(tag, base);
    held = rsp_data;
    @(negedge clk);
    check({tag, " rsp pulse"}, 64'(rsp_valid), 64'd0);
    check({tag, " ready after"}, 64'(cmd_ready), 64'd1);
    check({tag, " rsp held"}, 64'(rsp_data), 64'(held));
  endtask

  initial begin
    int base, rvc, w;
    logic [31:0] rd;
    #5;
    check("reset tck", 64'(jtag_clk), 64'd0);
    check("reset tms", 64'(jtag_mode), 64'd1);
    check("reset tdi", 64'(jtag_digital_input), 64'd0);
    check("reset ready", 64'(cmd_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_data", 64'(rsp_data), 64'd0);
    check("reset rsp_err", 64'(rsp_err), 64'd0);
    repeat (3) @(negedge clk);

    base  = tms_log.size();
    rst_n = 1'b1;
    wait_ready("por");
    build_exp(0, 0, 32'd0);
    check_seq("por", base);
    check("por no rsp", 64'(rv_count), 64'd0);
    if (rise_t.size() >= base + 2)
      check("tck period ns", 64'(rise_t[base + 1] - rise_t[base]), 64'd800);
    else
      check("tck period rises", 64'(rise_t.size() - base), 64'd2);

    do_cmd("ir load", 1, 0, 32'h0, 1, 64'd0, 1'b0);
    do_cmd("dr idcode", 2, 32, $urandom, 32, 64'h1234_5679, 1'b0);
    do_cmd("dr bypass", 2, 8, 32'hAA, 1, 64'd0, 1'b1);
    do_cmd("dr len0", 2, 0, $urandom, 32, {$urandom, $urandom}, 1'b0);
    do_cmd("dr len40", 2, 40, $urandom, 32, {$urandom, $urandom}, 1'b0);
    do_cmd("tlr", 0, $urandom_range(0, 40), $urandom, 1, 64'd0, 1'b0);
    do_cmd("reserved", 3, $urandom_range(0, 40), $urandom, 1, 64'd0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      do_cmd($sformatf("rand%0d", k), $urandom_range(0, 3), $urandom_range(0, 40),
             $urandom, $urandom_range(1, 40), {$urandom, $urandom}, 1'b0);
    end

    // Reset in the middle of a long DR shift, then confirm the automatic TLR.
    dr_n   = 32;
    dr_cap = 64'hDEAD_BEEF;
    rd     = $urandom;
    base   = tms_log.size();
    issue("mid rst", 2, 32, rd);
    w = 0;
    while ((tms_log.size() - base) < 10 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("mid rst in shift", 64'((tms_log.size() - base) >= 10), 64'd1);
    rvc   = rv_count;
    rst_n = 1'b0;
    #1;
    check("mid rst tck", 64'(jtag_clk), 64'd0);
    check("mid rst tms", 64'(jtag_mode), 64'd1);
    check("mid rst tdi", 64'(jtag_digital_input), 64'd0);
    check("mid rst ready", 64'(cmd_ready), 64'd0);
    check("mid rst rsp_data", 64'(rsp_data), 64'd0);
    repeat (4) @(negedge clk);
    base  = tms_log.size();
    rst_n = 1'b1;
    wait_ready("mid rst por");
    build_exp(0, 0, 32'd0);
    check_seq("mid rst por", base);
    check("mid rst no rsp", 64'(rv_count), 64'(rvc));

    do_cmd("after rst", 2, 8, 32'h5A, 1, 64'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
